// File: rtl/stream_gen_mode.sv
// stream_gen_mode
//   Rate-paced, framed AXI4-Stream traffic generator with selectable payload
//   (counter, LFSR, walking-one, header+counter), enable gating, frame and
//   drop counters and a busy flag.
//
// Ports
//   clk, aresetn         : stream clock, asynchronous active-low reset
//   enable               : generate frames while high
//   mode                 : payload select (0 counter, 1 LFSR, 2 walk-1, 3 hdr+cnt)
//   frame_size           : beats per frame minus 1
//   data_rate            : cycles between beat ticks minus 1
//   tdata/tkeep/tlast/tvalid/tready : AXI4-Stream master side
//   frame_count          : frames whose tlast beat was accepted (wraps)
//   drop_count           : ticks lost to backpressure (saturates)
//   busy                 : a frame is in progress
module stream_gen_mode #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned SIZE_W    = 32,
  parameter int unsigned RATE_W    = 16,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [SIZE_W-1:0]   frame_size,
  input  logic [RATE_W-1:0]   data_rate,
  output logic [DATA_W-1:0]   tdata,
  output logic [DATA_W/8-1:0] tkeep,
  output logic                tlast,
  output logic                tvalid,
  input  logic                tready,
  output logic [31:0]         frame_count,
  output logic [31:0]         drop_count,
  output logic                busy
);

  localparam int unsigned IDX_W = $clog2(DATA_W);
  // Narrow buses keep only the low DATA_W bits of the seed.
  localparam logic [31:0] SEED_MASK =
    (DATA_W >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << DATA_W) - 64'd1);
  localparam logic [31:0] LFSR_RST = LFSR_SEED & SEED_MASK;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q;
  logic                tvalid_q, tlast_q, busy_q;
  logic [DATA_W-1:0]   tdata_q;
  logic [31:0]         frame_count_q, drop_count_q;
  logic [SIZE_W-1:0]   idx_q, size_q;
  logic [RATE_W-1:0]   rate_cnt_q, rate_q;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   word_q;
  logic [31:0]         lfsr_q;

  logic                tick, hs, frame_end, new_frame, load, drop;
  logic [1:0]          eff_mode;
  logic [SIZE_W-1:0]   eff_size, eff_idx;
  logic [IDX_W-1:0]    widx;
  logic [31:0]         frame_count_d;
  logic [31:0]         lfsr_d;
  logic [DATA_W-1:0]   lfsr_rep, walk, payload_d;

  assign tdata       = tdata_q;
  assign tkeep       = '1;
  assign tlast       = tlast_q;
  assign tvalid      = tvalid_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;

  // '>=' rather than '==' so a smaller rate latched at a back-to-back frame
  // boundary wraps at once instead of running the counter all the way round.
  assign tick      = (state_q == RUN) && (rate_cnt_q >= rate_q);
  assign hs        = tvalid_q && tready;
  assign frame_end = hs && tlast_q;
  assign new_frame = frame_end && enable;
  assign drop      = tick && tvalid_q && !tready;
  assign load      = tick && (!tvalid_q || tready) && !(frame_end && !enable);

  // When a frame ends and the next one starts in the same cycle, the beat
  // loaded there already belongs to the new frame and its fresh config.
  assign eff_mode = new_frame ? mode       : mode_q;
  assign eff_size = new_frame ? frame_size : size_q;
  assign eff_idx  = new_frame ? '0         : idx_q;

  assign frame_count_d = frame_end ? frame_count_q + 32'd1 : frame_count_q;
  assign lfsr_d        = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  assign widx          = IDX_W'(eff_idx % SIZE_W'(DATA_W));
  assign walk          = DATA_W'(1) << widx;

  // Wide buses repeat the 32-bit LFSR word across every lane.
  for (genvar g = 0; g < DATA_W; g++) begin : g_rep
    assign lfsr_rep[g] = lfsr_q[g % 32];
  end

  // Payload for the beat being loaded this cycle.
  always_comb begin
    payload_d = '0;
    case (eff_mode)
      2'd0:    payload_d = word_q;
      2'd1:    payload_d = lfsr_rep;
      2'd2:    payload_d = walk;
      default: payload_d = (eff_idx == '0) ? DATA_W'(frame_count_d) : DATA_W'(eff_idx);
    endcase
  end

  // Frame FSM, pacing counter, beat loading and statistics.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      busy_q        <= 1'b0;
      tdata_q       <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      idx_q         <= '0;
      size_q        <= '0;
      rate_cnt_q    <= '0;
      rate_q        <= '0;
      mode_q        <= '0;
      word_q        <= '0;
      lfsr_q        <= LFSR_RST;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            mode_q     <= mode;
            size_q     <= frame_size;
            rate_q     <= data_rate;
            idx_q      <= '0;
            rate_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          rate_cnt_q <= tick ? '0 : rate_cnt_q + RATE_W'(1);
          if (frame_end) begin
            frame_count_q <= frame_count_d;
            if (enable) begin
              mode_q <= mode;
              size_q <= frame_size;
              rate_q <= data_rate;
              idx_q  <= '0;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          if (drop && (drop_count_q != 32'hFFFF_FFFF)) begin
            drop_count_q <= drop_count_q + 32'd1;
          end
          if (load) begin
            tdata_q  <= payload_d;
            tlast_q  <= (eff_idx == eff_size);
            tvalid_q <= 1'b1;
            idx_q    <= eff_idx + SIZE_W'(1);
            if (eff_mode == 2'd0) word_q <= word_q + DATA_W'(1);
            if (eff_mode == 2'd1) lfsr_q <= lfsr_d;
          end else if (hs) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stream_gen_mode.md
Name: stream_gen_mode

Overview:
- Parametrised successor to the single-mode AXI4-Stream frame generator that feeds the DMA stream_in port.
- Produces rate-paced, framed AXI4-Stream test traffic of configurable width.
- Selectable payload modes: counter, LFSR, walking-one, and header+counter.
- Adds enable gating, frame and drop counters, and a busy flag for software and ILA observation.

Parameters:
- DATA_W, 32: tdata width in bits; multiple of 8, range 8..256.
- SIZE_W, 32: width of frame_size.
- RATE_W, 16: width of data_rate.
- LFSR_SEED, 32'h0000_0001: LFSR reset/seed value; must be non-zero.

Ports:
- clk, input, 1: stream clock; all logic is on the rising edge.
- aresetn, input, 1: asynchronous active-low reset.
- enable, input, 1: generate frames while high.
- mode, input, 2: payload select; 0 counter, 1 LFSR, 2 walking-one, 3 header+counter.
- frame_size, input, SIZE_W: beats per frame minus 1.
- data_rate, input, RATE_W: cycles between beat-generation ticks minus 1.
- tdata, output, DATA_W: stream data.
- tkeep, output, DATA_W/8: byte enables.
- tlast, output, 1: last beat of frame.
- tvalid, output, 1: beat valid.
- tready, input, 1: downstream ready.
- frame_count, output, 32: completed frames (tlast accepted).
- drop_count, output, 32: rate ticks lost to backpressure.
- busy, output, 1: high while a frame is in progress.

Behaviour:
Reset (aresetn low, asynchronous):
- tvalid, tlast, busy = 0.
- tdata = 0, tkeep = all ones.
- frame_count, drop_count, beat index, rate counter, word counter = 0.
- LFSR = LFSR_SEED[DATA_W-1:0] (low DATA_W bits, zero-extended if DATA_W > 32).
- State = IDLE.

General:
- tkeep is constant all-ones after reset; there are no partial beats.
- Frame start: mode, frame_size and data_rate are latched. Input changes mid-frame take effect at the next frame only.

Rate counter:
- Free-runs from 0 to the latched data_rate, then wraps to 0.
- A tick is asserted in the cycle the counter equals data_rate.
- data_rate = 0 gives a tick every cycle.
- The counter runs only in RUN state and is cleared on entry to RUN.

State machine:
- IDLE: busy = 0, tvalid = 0. If enable = 1, latch config, clear beat index, go to RUN. The first tick occurs data_rate cycles after entry.
- RUN (busy = 1), on a tick:
  - If tvalid = 0, or tvalid = 1 and tready = 1 in this cycle: load the next beat and assert tvalid the next cycle. Latency is one cycle from tick to tvalid.
  - If tvalid = 1 and tready = 0: the tick is dropped, drop_count increments (saturating at 2^32-1), and the held beat is unchanged.
- Beat handshake (AXIS rules):
  - tdata and tlast are held stable while tvalid = 1 and tready = 0.
  - tvalid never drops without a handshake.
  - If a handshake occurs with no tick in the same cycle, tvalid goes to 0 the next cycle.
- Beat index: increments on each beat load and covers 0..frame_size. tlast = 1 on index == frame_size.
- End of frame, on tlast accepted:
  - frame_count increments (wraps).
  - If enable = 1: latch new config and start the next frame back-to-back in RUN, with index 0 and the rate counter continuing.
  - If enable = 0: go to IDLE.
- Deasserting enable mid-frame never truncates the frame; it completes normally.
- frame_size = 0 gives single-beat frames with tlast on every beat.

Payload, per loaded beat:
- Mode 0: tdata = word counter. The counter increments per loaded beat, wraps at 2^DATA_W, and persists across frames.
- Mode 1: tdata = LFSR. The LFSR advances once per loaded beat, Fibonacci form, taps on bits 31, 21, 1, 0 (x^32+x^22+x^2+x+1) on the low 32 bits. For DATA_W > 32, the low 32 bits are replicated.
- Mode 2: tdata = 1 << (index mod DATA_W).
- Mode 3:
  - Index 0: tdata = frame_count (zero-extended or truncated to DATA_W).
  - Other beats: tdata = index.
- Mode switches take effect only at frame start. The word counter and LFSR keep their state across mode changes.

Reset mid-frame:
- Everything returns immediately to reset values.
- The partial frame is abandoned with no tlast; downstream must tolerate this.

Test Plan:
- Back-to-back counter frames: mode=0, frame_size=3, data_rate=0, tready=1, enable=1 -> tvalid continuous from 2 cycles after enable; tdata 0,1,2,3,4,...; tlast on tdata 3, 7, 11; frame_count 1, 2, 3 after each tlast.
- Pacing: mode=3, frame_size=2, data_rate=4, tready=1 -> one beat every 5 cycles; tdata 0,1,2 with tlast on 2, then 1,1,2 with tlast on 2; drop_count stays 0.
- Backpressure drops: mode=0, data_rate=1, tready held 0 for 10 cycles after the first tvalid -> tdata held at 0 with tvalid high; drop_count = 5; after tready=1 the next beat carries tdata=1 (no gap in sequence values).
- Enable drop mid-frame: frame_size=7, deassert enable at beat 2 -> beats 3..7 still sent, tlast on beat 7, then IDLE with busy=0; frame_count=1.
- LFSR/walking-one: DATA_W=32, mode=1, seed=1 -> first beats 0x00000001 then successive LFSR values matching the reference model; mode=2, frame_size=33 -> 1,2,4,...,0x80000000,1,2.
- Async reset mid-frame: pulse aresetn low for 1 ns between clock edges at beat 2 -> tvalid=0, counters=0 immediately; after release with enable=1, a new frame starts at word 0.
